// File: rtl/cd_pkg.sv
// Shared definitions for the cdbus SPI-to-CSR bridge.
//   CD_CSR_ADDR_W : CSR address width of the cdbus controller register port
//   HDR_WR        : header bit selecting write (1) or read (0)
//   HDR_FIXED     : header bit disabling address auto-increment
//   cd_state_e    : bridge transfer state
package cd_pkg;
  localparam int CD_CSR_ADDR_W = 5;
  localparam int HDR_WR        = 7;
  localparam int HDR_FIXED     = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } cd_state_e;
endpackage

// File: rtl/cd_sync.sv
// Multi-flop synchroniser for one asynchronous input bit.
//   clk, reset_n : system clock, async active-low reset
//   d            : asynchronous input
//   q            : synchronised output, STAGES clocks of latency
// RST_VAL sets the value every stage takes in reset.
module cd_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] pipe_q, pipe_d;

  always_comb pipe_d = {pipe_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pipe_q <= {STAGES{RST_VAL}};
    else          pipe_q <= pipe_d;
  end

  assign q = pipe_q[STAGES-1];
endmodule

// File: rtl/cd_spi_csr_bridge.sv
// SPI-slave (mode 3, MSB first) to CSR-bus initiator for the cdbus controller.
// A header byte selects read/write, fixed/incrementing address and the start
// address; each following data byte produces one single-cycle CSR strobe.
//   clk, reset_n        : system clock (>= 8x sck), async active-low reset
//   sck, cs_n, mosi     : SPI pins, asynchronous to clk
//   miso, miso_oe       : SPI data out and its pad enable
//   csr_address         : registered CSR address
//   csr_read            : one-clk read strobe, csr_readdata sampled same clk
//   csr_write           : one-clk write strobe with csr_writedata
module cd_spi_csr_bridge
  import cd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = CD_CSR_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] csr_address,
  output logic              csr_read,
  input  logic [7:0]        csr_readdata,
  output logic              csr_write,
  output logic [7:0]        csr_writedata
);
  logic sck_s, cs_n_s, mosi_s;

  // sck idles high in mode 3. cs_n resets to "asserted" so that a select held
  // low across reset is not mistaken for a new transfer; see armed_q.
  cd_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
    .clk(clk), .reset_n(reset_n), .d(sck),  .q(sck_s));
  cd_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .d(cs_n), .q(cs_n_s));
  cd_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .d(mosi), .q(mosi_s));

  cd_state_e         state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [6:0]        tx_q, tx_d;       // bits still to be shifted out after miso
  logic              miso_q, miso_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              fixed_q, fixed_d;
  logic              sck_prev_q, sck_prev_d;
  logic              armed_q, armed_d;  // set once cs_n has been seen high after reset

  logic              sck_rise, sck_fall, cs_act, read_stb;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] addr_keep;

  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign cs_act    = armed_q & ~cs_n_s;
  assign rx_byte   = {rx_q[6:0], mosi_s};
  // Post-write increment lands the clk after the write strobe.
  assign addr_keep = (write_q && !fixed_q) ? addr_q + ADDR_W'(1) : addr_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    addr_d     = addr_keep;
    wdata_d    = wdata_q;
    write_d    = 1'b0;
    fixed_d    = fixed_q;
    sck_prev_d = sck_s;
    armed_d    = armed_q | cs_n_s;
    read_stb   = 1'b0;

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (cs_act) begin
          state_d = HDR;
          miso_d  = 1'b0;
        end else begin
          miso_d  = 1'b1;
        end
      end
      HDR: begin
        miso_d = 1'b0;
        if (sck_rise) begin
          rx_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            fixed_d = rx_byte[HDR_FIXED];
            addr_d  = rx_byte[ADDR_W-1:0];
            state_d = rx_byte[HDR_WR] ? WDATA : RDATA;
          end
        end
      end
      WDATA: begin
        if (sck_rise) begin
          rx_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            write_d = 1'b1;
            wdata_d = rx_byte;
          end
        end
      end
      RDATA: begin
        if (sck_rise) bit_cnt_d = bit_cnt_q + 3'd1;
        // The only fall seen with the counter at 0 is the one opening a byte,
        // so the read is issued only for bytes the master actually clocks.
        if (sck_fall) begin
          if (bit_cnt_q == 3'd0) begin
            read_stb = 1'b1;
            miso_d   = csr_readdata[7];
            tx_d     = csr_readdata[6:0];
            if (!fixed_q) addr_d = addr_q + ADDR_W'(1);
          end else begin
            miso_d   = tx_q[6];
            tx_d     = {tx_q[5:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Deselect overrides everything decoded this clk, including an 8th rise.
    if (state_q != IDLE && !cs_act) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      write_d   = 1'b0;
      read_stb  = 1'b0;
      addr_d    = addr_keep;
      tx_d      = tx_q;
      miso_d    = 1'b1;
      fixed_d   = fixed_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      fixed_q    <= 1'b0;
      sck_prev_q <= 1'b1;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      fixed_q    <= fixed_d;
      sck_prev_q <= sck_prev_d;
      armed_q    <= armed_d;
    end
  end

  assign miso          = miso_q;
  assign miso_oe       = cs_act;
  assign csr_address   = addr_q;
  assign csr_read      = read_stb;
  assign csr_write     = write_q;
  assign csr_writedata = wdata_q;
endmodule

// File: tb/tb_cd_spi_csr_bridge.sv
// Self-checking bench: SPI mode-3 master at f_clk/8, CSR slave returning
// addr^0x5A, scoreboard of expected CSR strobes checked by a monitor.
module tb_cd_spi_csr_bridge;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic       sck = 1'b1, cs_n = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe, csr_read, csr_write;
  logic [4:0] csr_address;
  logic [7:0] csr_readdata, csr_writedata;

  assign csr_readdata = {3'b000, csr_address} ^ 8'h5A;

  cd_spi_csr_bridge #(.SYNC_STAGES(2), .ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .csr_address(csr_address),
    .csr_read(csr_read), .csr_readdata(csr_readdata),
    .csr_write(csr_write), .csr_writedata(csr_writedata));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  typedef struct {
    bit       wr;
    bit [4:0] addr;
    bit [7:0] data;
  } ev_t;
  ev_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every clk with a strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && (csr_read || csr_write)) begin
      ev_t e;
      chk("rd_wr_exclusive", 32'(csr_read & csr_write), 0);
      chk("strobe_while_selected", 32'(miso_oe), 1);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_strobe actual=rd%0d/wr%0d@0x%0h required=none",
                 csr_read, csr_write, csr_address);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind_wr", 32'(csr_write), 32'(e.wr));
        chk("strobe_addr", 32'(csr_address), 32'(e.addr));
        if (e.wr) chk("write_data", 32'(csr_writedata), 32'(e.data));
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      sck  = 1'b0;
      mosi = b[i];
      #40;
      r[i] = miso;
      sck  = 1'b1;
      #40;
    end
  endtask

  // Reference model: strobes and MISO bytes derived from the header rules,
  // then the transfer is clocked and checked.
  task automatic run(input logic [7:0] hdr, input int n, input logic [7:0] d[4],
                     input int tail_bits, input logic [7:0] tail);
    logic [4:0] a;
    logic [7:0] exp_miso[4];
    logic [7:0] rx[4];
    logic [7:0] junk;
    a = hdr[4:0];
    for (int k = 0; k < n; k++) begin
      ev_t e;
      e.wr = hdr[7]; e.addr = a; e.data = hdr[7] ? d[k] : 8'h00;
      exp_q.push_back(e);
      exp_miso[k] = {3'b000, a} ^ 8'h5A;
      if (!hdr[6]) a = a + 5'd1;
    end
    cs_n = 1'b0;
    #80;
    spi_bits(hdr, 8, junk);
    for (int k = 0; k < n; k++) spi_bits(d[k], 8, rx[k]);
    if (tail_bits > 0) spi_bits(tail, tail_bits, junk);
    #80;
    chk("miso_oe_selected", 32'(miso_oe), 1);
    cs_n = 1'b1;
    #120;
    chk("miso_oe_deselected", 32'(miso_oe), 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    exp_q.delete();
    if (!hdr[7])
      for (int k = 0; k < n; k++) chk($sformatf("miso_byte%0d", k), 32'(rx[k]), 32'(exp_miso[k]));
  endtask

  task automatic chk_reset_vals();
    chk("rst_miso", 32'(miso), 1);
    chk("rst_miso_oe", 32'(miso_oe), 0);
    chk("rst_csr_address", 32'(csr_address), 0);
    chk("rst_csr_read", 32'(csr_read), 0);
    chk("rst_csr_write", 32'(csr_write), 0);
    chk("rst_csr_writedata", 32'(csr_writedata), 0);
  endtask

  initial begin
    logic [7:0] d[4];
    logic [7:0] junk;
    logic [7:0] hdr;
    int n, tb_bits;

    #20;
    chk_reset_vals();
    reset_n = 1'b1;
    #100;

    d = '{8'hAB, 8'h00, 8'h00, 8'h00}; run(8'h91, 1, d, 0, 8'h00);
    d = '{8'h01, 8'h02, 8'h03, 8'h00}; run(8'h8C, 3, d, 0, 8'h00);
    d = '{8'h10, 8'h20, 8'h00, 8'h00}; run(8'hD5, 2, d, 0, 8'h00);
    d = '{8'h00, 8'h00, 8'h00, 8'h00}; run(8'h1F, 3, d, 0, 8'h00);
    run(8'h84, 0, d, 4, 8'hFF);
    d = '{8'h0A, 8'h00, 8'h00, 8'h00}; run(8'h84, 1, d, 0, 8'h00);

    // Reset in the middle of a data byte with cs_n held low: outputs return
    // at once, and bytes clocked before a fresh cs_n fall are ignored.
    cs_n = 1'b0;
    #80;
    spi_bits(8'h85, 8, junk);
    spi_bits(8'hFF, 4, junk);
    #20;
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    #30;
    reset_n = 1'b1;
    #80;
    spi_bits(8'h91, 8, junk);
    spi_bits(8'hAB, 8, junk);
    #80;
    chk("no_transfer_without_fresh_select", 32'(miso_oe), 0);
    cs_n = 1'b1;
    #120;
    chk("no_strobe_after_reset", 32'(exp_q.size()), 0);
    d = '{8'hAB, 8'h00, 8'h00, 8'h00}; run(8'h91, 1, d, 0, 8'h00);

    for (int t = 0; t < 24; t++) begin
      hdr = 8'($urandom);
      n   = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      tb_bits = (hdr[7] && ($urandom_range(0, 3) == 0)) ? $urandom_range(1, 7) : 0;
      run(hdr, n, d, tb_bits, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
